// File: rtl/swd_frame_engine.sv
// rtl/swd_frame_engine.sv - SWD host frame engine with WAIT retry and raw passthrough
module swd_frame_engine #(
    parameter int PAD_BITS     = 2,
    parameter int TURN_CYCLES  = 1,
    parameter int DATA_W       = 32,
    parameter int WAIT_RETRIES = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              apndp,
    input  logic              rnw,
    input  logic [1:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              raw_en,
    input  logic              raw_mosi,
    output logic              raw_miso,
    output logic              swdio_o,
    output logic              swdio_oe,
    input  logic              swdio_i,
    output logic              swclk_en,
    output logic              busy,
    output logic              done,
    output logic [2:0]        ack,
    output logic [DATA_W-1:0] rdata,
    output logic              parity_err,
    output logic [3:0]        retries_used
);

    typedef enum logic [3:0] {
        S_IDLE, S_PAD, S_REQ, S_TURN1, S_ACK, S_RDATA,
        S_RPAR, S_TURN2, S_WDATA, S_WPAR, S_DONE
    } state_t;

    // With no padding a frame (and every WAIT re-issue) begins directly at the request byte.
    localparam state_t FRAME_FIRST = (PAD_BITS == 0) ? S_REQ : S_PAD;

    localparam logic [4:0] PAD_LAST  = 5'(PAD_BITS - 1);
    localparam logic [4:0] TURN_LAST = 5'(TURN_CYCLES - 1);
    localparam logic [4:0] DATA_LAST = 5'(DATA_W - 1);

    state_t            state, state_n;
    logic [4:0]        cnt;
    logic [4:0]        phase_last;
    logic              last;
    logic              accept;
    logic [7:0]        req_byte;
    logic              rnw_q;
    logic [DATA_W-1:0] wr_sh;
    logic              wpar;
    logic [DATA_W-1:0] rd_sh;
    logic              par_q;
    logic [2:0]        ack_sh;
    logic [2:0]        ack_full;
    logic              retry;

    assign accept   = (state == S_IDLE) && start && !raw_en;
    assign ack_full = {swdio_i, ack_sh[2:1]};
    assign retry    = (ack == 3'b010) && (retries_used < 4'(WAIT_RETRIES));
    assign last     = (cnt == phase_last);
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);

    always_comb begin
        phase_last = 5'd0;
        case (state)
            S_PAD:            phase_last = PAD_LAST;
            S_REQ:            phase_last = 5'd7;
            S_TURN1, S_TURN2: phase_last = TURN_LAST;
            S_ACK:            phase_last = 5'd2;
            S_RDATA, S_WDATA: phase_last = DATA_LAST;
            default:          phase_last = 5'd0;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (accept) state_n = FRAME_FIRST;
            S_PAD:   if (last) state_n = S_REQ;
            S_REQ:   if (last) state_n = S_TURN1;
            S_TURN1: if (last) state_n = S_ACK;
            S_ACK:   if (last) state_n = (ack_full == 3'b001 && rnw_q) ? S_RDATA : S_TURN2;
            S_RDATA: if (last) state_n = S_RPAR;
            S_RPAR:  state_n = S_TURN2;
            S_TURN2: begin
                if (last) begin
                    if (ack == 3'b001 && !rnw_q) state_n = S_WDATA;
                    else if (retry)              state_n = FRAME_FIRST;
                    else                         state_n = S_DONE;
                end
            end
            S_WDATA: if (last) state_n = S_WPAR;
            S_WPAR:  state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Pin drive depends only on registered state, except the raw passthrough in IDLE.
    always_comb begin
        swdio_o  = 1'b0;
        swdio_oe = 1'b0;
        raw_miso = 1'b0;
        swclk_en = 1'b0;
        case (state)
            S_IDLE: begin
                swdio_oe = raw_en;
                swdio_o  = raw_en & raw_mosi;
                raw_miso = raw_en & swdio_i;
                swclk_en = raw_en;
            end
            S_PAD:   begin swdio_oe = 1'b1; swclk_en = 1'b1; end
            S_REQ:   begin swdio_oe = 1'b1; swdio_o = req_byte[cnt[2:0]]; swclk_en = 1'b1; end
            S_WDATA: begin swdio_oe = 1'b1; swdio_o = wr_sh[0]; swclk_en = 1'b1; end
            S_WPAR:  begin swdio_oe = 1'b1; swdio_o = wpar; swclk_en = 1'b1; end
            S_DONE:  swclk_en = 1'b0;
            default: swclk_en = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= 5'd0;
            req_byte     <= 8'd0;
            rnw_q        <= 1'b0;
            wr_sh        <= '0;
            wpar         <= 1'b0;
            rd_sh        <= '0;
            par_q        <= 1'b0;
            ack_sh       <= 3'd0;
            ack          <= 3'd0;
            rdata        <= '0;
            parity_err   <= 1'b0;
            retries_used <= 4'd0;
        end else begin
            state <= state_n;
            cnt   <= (state == S_IDLE || last) ? 5'd0 : cnt + 5'd1;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_byte     <= {1'b1, 1'b0, apndp ^ rnw ^ addr[0] ^ addr[1],
                                         addr[1], addr[0], rnw, apndp, 1'b1};
                        rnw_q        <= rnw;
                        wr_sh        <= wdata;
                        wpar         <= ^wdata;
                        retries_used <= 4'd0;
                    end
                end
                S_ACK: begin
                    ack_sh <= ack_full;
                    if (last) ack <= ack_full;
                end
                S_RDATA: rd_sh <= {swdio_i, rd_sh[DATA_W-1:1]};
                S_RPAR:  par_q <= swdio_i;
                S_TURN2: if (last && !(ack == 3'b001 && !rnw_q) && retry)
                             retries_used <= retries_used + 4'd1;
                S_WDATA: wr_sh <= {1'b0, wr_sh[DATA_W-1:1]};
                default: ;
            endcase
            // Results are published on entry to DONE so they are valid alongside the pulse.
            if (state != S_DONE && state_n == S_DONE) begin
                if (ack == 3'b001 && rnw_q) begin
                    rdata      <= rd_sh;
                    parity_err <= par_q ^ (^rd_sh);
                end else begin
                    parity_err <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_swd_frame_engine.sv
// tb/tb_swd_frame_engine.sv - scoreboard bench for swd_frame_engine with frame-level target model
module tb_swd_frame_engine;

    localparam int PAD  = 2;
    localparam int TURN = 1;
    localparam int DW   = 32;
    localparam int WR   = 3;

    logic          clk = 1'b0;
    logic          rst_n, start, apndp, rnw;
    logic [1:0]    addr;
    logic [DW-1:0] wdata;
    logic          raw_en, raw_mosi, raw_miso;
    logic          swdio_o, swdio_oe, swdio_i, swclk_en;
    logic          busy, done;
    logic [2:0]    ack;
    logic [DW-1:0] rdata;
    logic          parity_err;
    logic [3:0]    retries_used;

    swd_frame_engine #(
        .PAD_BITS(PAD), .TURN_CYCLES(TURN), .DATA_W(DW), .WAIT_RETRIES(WR)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .apndp(apndp), .rnw(rnw),
        .addr(addr), .wdata(wdata), .raw_en(raw_en), .raw_mosi(raw_mosi),
        .raw_miso(raw_miso), .swdio_o(swdio_o), .swdio_oe(swdio_oe),
        .swdio_i(swdio_i), .swclk_en(swclk_en), .busy(busy), .done(done),
        .ack(ack), .rdata(rdata), .parity_err(parity_err),
        .retries_used(retries_used)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           len;
        logic [127:0] oe;
        logic [127:0] o;
        logic [2:0]   ack;
        logic [31:0]  rdata;
        logic         perr;
        logic [3:0]   retries;
    } exp_t;

    exp_t         exp_q[$];
    logic         tgt_bits [0:255];
    logic [31:0]  model_rdata = '0;
    int           checks = 0;
    int           passed = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Frame-level reference: lays out each frame as a list of bits from the protocol rules.
    task automatic plan(input logic a, input logic r, input logic [1:0] ad,
                        input logic [31:0] wd, input logic [31:0] rd, input logic flip,
                        input int n_wait, input logic [2:0] final_ack, output exp_t e);
        int k = 0;
        int rt = 0;
        bit fin = 0;
        logic [2:0] resp;
        logic [7:0] rq;
        rq = {1'b1, 1'b0, a ^ r ^ ad[0] ^ ad[1], ad[1], ad[0], r, a, 1'b1};
        e.oe = '0;
        e.o  = '0;
        resp = final_ack;
        for (int i = 0; i < 256; i++) tgt_bits[i] = 1'($urandom);
        while (!fin) begin
            resp = (rt < n_wait) ? 3'b010 : final_ack;
            for (int i = 0; i < PAD; i++) begin e.oe[k] = 1'b1; e.o[k] = 1'b0; k++; end
            for (int i = 0; i < 8; i++) begin e.oe[k] = 1'b1; e.o[k] = rq[i]; k++; end
            k += TURN;
            for (int i = 0; i < 3; i++) begin tgt_bits[k] = resp[i]; k++; end
            if (resp == 3'b001 && r) begin
                for (int i = 0; i < DW; i++) begin tgt_bits[k] = rd[i]; k++; end
                tgt_bits[k] = (^rd) ^ flip;
                k += 1 + TURN;
                fin = 1;
            end else if (resp == 3'b001) begin
                k += TURN;
                for (int i = 0; i < DW; i++) begin e.oe[k] = 1'b1; e.o[k] = wd[i]; k++; end
                e.oe[k] = 1'b1; e.o[k] = ^wd; k++;
                fin = 1;
            end else begin
                k += TURN;
                if (resp == 3'b010 && rt < WR) rt++;
                else fin = 1;
            end
        end
        e.len     = k;
        e.ack     = resp;
        e.retries = 4'(rt);
        e.perr    = (resp == 3'b001) && r && flip;
        if (resp == 3'b001 && r) model_rdata = rd;
        e.rdata   = model_rdata;
    endtask

    task automatic pulse_start(input logic a, input logic r, input logic [1:0] ad,
                               input logic [31:0] wd);
        @(posedge clk); #1;
        start = 1'b1; apndp = a; rnw = r; addr = ad; wdata = wd;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic issue(input logic a, input logic r, input logic [1:0] ad,
                         input logic [31:0] wd, input logic [31:0] rd, input logic flip,
                         input int n_wait, input logic [2:0] final_ack);
        exp_t e;
        int   c = 0;
        plan(a, r, ad, wd, rd, flip, n_wait, final_ack, e);
        exp_q.push_back(e);
        pulse_start(a, r, ad, wd);
        while (!done && c < 600) begin @(negedge clk); c++; end
        chk("done_seen", done, 1'b1);
        @(negedge clk);
    endtask

    // Target: supplies the planned bit for each frame bit while a frame runs.
    int tbit = 0;
    always @(posedge clk) begin
        #1;
        if (busy && !done) begin
            if (tbit < 256) swdio_i = tgt_bits[tbit];
            tbit++;
        end else begin
            tbit = 0;
        end
    end

    // Monitor: captures host-driven bits and checks results against the scoreboard on done.
    int           mbit = 0;
    logic [127:0] cap_oe = '0;
    logic [127:0] cap_o = '0;
    bit           post_done = 0;
    always @(negedge clk) begin
        exp_t e;
        if (post_done) begin
            chk("done_one_cycle", {done, busy}, 2'b00);
            post_done = 0;
        end
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: got done=1 expected no pending transaction");
            end else begin
                e = exp_q.pop_front();
                chk("frame_len", 128'(mbit), 128'(e.len));
                chk("oe_pattern", cap_oe, e.oe);
                chk("o_pattern", cap_o & e.oe, e.o);
                chk("ack", ack, e.ack);
                chk("rdata", rdata, e.rdata);
                chk("parity_err", parity_err, e.perr);
                chk("retries_used", retries_used, e.retries);
            end
            mbit = 0; cap_oe = '0; cap_o = '0;
            post_done = 1;
        end else if (busy) begin
            if (mbit < 128) begin
                cap_oe[mbit] = swdio_oe;
                cap_o[mbit]  = swdio_o;
            end
            mbit++;
        end else begin
            mbit = 0; cap_oe = '0; cap_o = '0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        exp_t        dummy;
        logic [15:0] pat;
        logic [2:0]  fa;
        int          sel;
        rst_n = 1'b0; start = 1'b0; apndp = 1'b0; rnw = 1'b0; addr = 2'b00;
        wdata = '0; raw_en = 1'b0; raw_mosi = 1'b0; swdio_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_oe_o", {swdio_oe, swdio_o}, 2'b00);
        chk("rst_swclk_en", swclk_en, 1'b0);
        chk("rst_ack", ack, 3'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_perr_retries", {parity_err, retries_used}, 5'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Read OK with request byte 0xA5, then the same read with a corrupted parity bit.
        issue(1'b0, 1'b1, 2'b00, 32'h0, 32'h12345678, 1'b0, 0, 3'b001);
        issue(1'b0, 1'b1, 2'b00, 32'h0, 32'h12345678, 1'b1, 0, 3'b001);
        issue(1'b1, 1'b0, 2'b01, 32'hDEADBEEF, 32'h0, 1'b0, 0, 3'b001);
        issue(1'b1, 1'b1, 2'b01, 32'h0, 32'hCAFEF00D, 1'b0, 15, 3'b010);

        // Abort a read at frame bit 20 with reset.
        plan(1'b0, 1'b1, 2'b10, 32'h0, 32'h55AA55AA, 1'b0, 0, 3'b001, dummy);
        pulse_start(1'b0, 1'b1, 2'b10, 32'h0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_oe", swdio_oe, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_rdata", rdata, 32'd0);
        model_rdata = '0;
        issue(1'b1, 1'b1, 2'b11, 32'h0, 32'h0F0F1234, 1'b0, 1, 3'b001);

        // Raw passthrough with start held high.
        pat = 16'hA5C3;
        @(posedge clk); #1;
        raw_en = 1'b1; start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            raw_mosi = pat[i];
            swdio_i  = 1'($urandom);
            @(negedge clk);
            chk("raw_o", swdio_o, pat[i]);
            chk("raw_oe_busy", {swdio_oe, busy, swclk_en}, 3'b101);
            chk("raw_miso", raw_miso, swdio_i);
            @(posedge clk); #1;
        end
        raw_en = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("raw_exit_idle", {busy, swdio_oe}, 2'b00);

        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                3:       fa = 3'b100;
                4:       fa = 3'b111;
                5:       fa = 3'b010;
                default: fa = 3'b001;
            endcase
            issue(1'($urandom), 1'($urandom), 2'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 3) == 0), $urandom_range(0, 5), fa);
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
